// File: rtl/dot_pkg.sv
// Shared helpers for the dot-product datapath.
//   clog2     : ceil(log2(n)), 0 for n<=1
//   sw_f      : adder-tree output width for given operand widths / lane count
//   lat_f     : input-to-result latency in register stages
//   lanes_at  : live lane count at a given adder-tree level
//   accw_ok   : elaboration guard, accumulator must hold a full beat sum
package dot_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int sw_f(input int sa, input int sb, input int dot);
    return sa + sb + clog2(dot);
  endfunction

  function automatic int lat_f(input int dot);
    return clog2(dot) + 3;
  endfunction

  function automatic int lanes_at(input int n, input int lvl);
    return (n + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic bit accw_ok(input int accw, input int sa, input int sb, input int dot);
    return accw >= sw_f(sa, sb, dot);
  endfunction

endpackage

// File: rtl/dot_adder_tree.sv
// Registered pairwise adder tree with valid/last sideband.
//   clk, rst      : clock, async active-high reset
//   en            : global advance enable; all levels freeze when low
//   in_valid/last : sideband travelling with in_data
//   in_data       : N lanes of W-bit signed values, lane j at [j*W +: W]
//   out_valid/last: sideband aligned with out_sum
//   out_sum       : OW-bit signed sum, clog2(N) register levels after input
// Every level is carried at OW bits; the upper bits of early levels are pure
// sign extension so the result equals a tree growing one bit per level.
module dot_adder_tree
  import dot_pkg::*;
#(
  parameter int N  = 6,
  parameter int W  = 16,
  parameter int OW = W + clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [N*W-1:0]    in_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [OW-1:0]     out_sum
);

  localparam int T = clog2(N);

  for (genvar l = 0; l <= T; l++) begin : g_lvl
    localparam int NL = lanes_at(N, l);
    logic [NL-1:0][OW-1:0] node;
    logic                  vld;
    logic                  lst;

    if (l == 0) begin : g_in
      for (genvar j = 0; j < N; j++) begin : g_lane
        assign node[j] = OW'($signed(in_data[j*W +: W]));
      end
      assign vld = in_valid;
      assign lst = in_last;
    end else begin : g_add
      localparam int PL = lanes_at(N, l - 1);
      logic [NL-1:0][OW-1:0] node_d;
      logic [NL-1:0][OW-1:0] node_q;
      logic                  vld_q;
      logic                  lst_q;

      for (genvar j = 0; j < NL; j++) begin : g_lane
        // odd lane count: the unpaired top lane passes straight through
        if (2*j + 1 < PL) begin : g_pair
          assign node_d[j] = g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
        end else begin : g_pass
          assign node_d[j] = g_lvl[l-1].node[2*j];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          node_q <= '0;
          vld_q  <= 1'b0;
          lst_q  <= 1'b0;
        end else if (en) begin
          node_q <= node_d;
          vld_q  <= g_lvl[l-1].vld;
          lst_q  <= g_lvl[l-1].lst;
        end
      end

      assign node = node_q;
      assign vld  = vld_q;
      assign lst  = lst_q;
    end
  end

  assign out_sum   = g_lvl[T].node[0];
  assign out_valid = g_lvl[T].vld;
  assign out_last  = g_lvl[T].lst;

endmodule

// File: rtl/dot_accum_pipe.sv
// Pipelined signed dot-product engine with multi-beat accumulation.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : beat handshake; in_last marks a vector's final beat
//   din_a, din_b        : DOT signed lanes, lane i at [i*SIZE +: SIZE]
//   out_valid/out_ready : result handshake
//   dout                : ACCW-bit signed (wrapping) dot product of the vector
//   out_ovf             : sticky signed overflow seen while accumulating it
// Stages: S0 input regs, S1 products, clog2(DOT) tree levels, accumulate.
// The result is visible after the lat_f(DOT)-th clock edge, counting the
// edge that accepts the last beat as the first.
module dot_accum_pipe
  import dot_pkg::*;
#(
  parameter int SIZEA = 8,
  parameter int SIZEB = 8,
  parameter int DOT   = 6,
  parameter int ACCW  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [DOT*SIZEA-1:0]  din_a,
  input  logic [DOT*SIZEB-1:0]  din_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACCW-1:0]       dout,
  output logic                  out_ovf
);

  localparam int PW = SIZEA + SIZEB;
  localparam int SW = sw_f(SIZEA, SIZEB, DOT);

  if (!accw_ok(ACCW, SIZEA, SIZEB, DOT)) begin : g_chk
    $error("dot_accum_pipe: ACCW too narrow for one beat sum");
  end

  logic                 en;
  logic [DOT*SIZEA-1:0] a_q;
  logic [DOT*SIZEB-1:0] b_q;
  logic [DOT*PW-1:0]    prod_d, prod_q;
  logic [1:0]           vld_pipe_q, lst_pipe_q;
  logic                 tree_vld, tree_last;
  logic [SW-1:0]        tree_sum;

  logic [ACCW-1:0] acc_q, acc_d, dout_q, dout_d;
  logic [ACCW-1:0] sum_ext, acc_add, acc_new;
  logic            add_ovf, ovf_new;
  logic            ovf_acc_q, ovf_acc_d, first_q, first_d;
  logic            out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;

  // A held, unconsumed result freezes the whole pipe.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  for (genvar i = 0; i < DOT; i++) begin : g_mul
    logic signed [PW-1:0] pa, pb;
    assign pa = PW'($signed(a_q[i*SIZEA +: SIZEA]));
    assign pb = PW'($signed(b_q[i*SIZEB +: SIZEB]));
    assign prod_d[i*PW +: PW] = pa * pb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      vld_pipe_q <= '0;
      lst_pipe_q <= '0;
    end else if (en) begin
      a_q        <= din_a;
      b_q        <= din_b;
      prod_q     <= prod_d;
      vld_pipe_q <= {vld_pipe_q[0], in_valid};
      lst_pipe_q <= {lst_pipe_q[0], in_last};
    end
  end

  dot_adder_tree #(.N(DOT), .W(PW), .OW(SW)) u_tree (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (vld_pipe_q[1]),
    .in_last   (lst_pipe_q[1]),
    .in_data   (prod_q),
    .out_valid (tree_vld),
    .out_last  (tree_last),
    .out_sum   (tree_sum)
  );

  always_comb begin
    sum_ext = ACCW'($signed(tree_sum));
    acc_add = acc_q + sum_ext;
    // same-sign operands producing a different-sign result
    add_ovf = (acc_q[ACCW-1] == sum_ext[ACCW-1]) && (acc_add[ACCW-1] != acc_q[ACCW-1]);
    acc_new = first_q ? sum_ext : acc_add;
    ovf_new = first_q ? 1'b0 : (ovf_acc_q | add_ovf);

    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    first_d     = first_q;
    dout_d      = dout_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q && !out_ready;

    if (en && tree_vld) begin
      acc_d     = acc_new;
      ovf_acc_d = ovf_new;
      first_d   = tree_last;
      // a landing last beat wins over a same-cycle consume
      if (tree_last) begin
        dout_d      = acc_new;
        out_ovf_d   = ovf_new;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      first_q     <= 1'b1;
      dout_q      <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      first_q     <= first_d;
      dout_q      <= dout_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dot_accum_pipe.sv
module tb_dot_accum_pipe;
  localparam int DOT = 6;
  localparam int SA  = 8;
  localparam int SB  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [DOT*SA-1:0]   din_a = '0;
  logic [DOT*SB-1:0]   din_b = '0;
  logic                in_ready, in_ready20, ov32, ov20, ovf32, ovf20;
  logic [31:0]         dout32;
  logic [19:0]         dout20;

  // Two widths share one stimulus stream; pipeline timing is width-independent.
  dot_accum_pipe #(.SIZEA(SA), .SIZEB(SB), .DOT(DOT), .ACCW(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .din_a(din_a), .din_b(din_b), .out_valid(ov32), .out_ready(out_ready),
    .dout(dout32), .out_ovf(ovf32));

  dot_accum_pipe #(.SIZEA(SA), .SIZEB(SB), .DOT(DOT), .ACCW(20)) dut20 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready20), .in_last(in_last),
    .din_a(din_a), .din_b(din_b), .out_valid(ov20), .out_ready(out_ready),
    .dout(dout20), .out_ovf(ovf20));

  int tests = 0, fails = 0, stalls = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { longint d; bit o; } exp_t;
  exp_t   q32[$], q20[$];
  longint m_acc32 = 0, m_acc20 = 0;
  bit     m_ovf32 = 0, m_ovf20 = 0, m_first = 1;

  function automatic longint wrap(input longint x, input int w);
    longint m, r;
    m = 64'sd1 <<< w;
    r = x & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic longint beat_sum(input logic [DOT*SA-1:0] a, input logic [DOT*SB-1:0] b);
    longint s;
    byte    sa, sb;
    s = 0;
    for (int i = 0; i < DOT; i++) begin
      sa = a[i*SA +: SA];
      sb = b[i*SB +: SB];
      s += longint'(sa) * longint'(sb);
    end
    return s;
  endfunction

  task automatic model_beat(input logic [DOT*SA-1:0] a, input logic [DOT*SB-1:0] b, input bit last);
    longint s, e;
    exp_t   x;
    s = beat_sum(a, b);
    if (m_first) begin
      m_acc32 = wrap(s, 32); m_acc20 = wrap(s, 20);
      m_ovf32 = 0;           m_ovf20 = 0;
    end else begin
      e = m_acc32 + s; m_ovf32 |= (e != wrap(e, 32)); m_acc32 = wrap(e, 32);
      e = m_acc20 + s; m_ovf20 |= (e != wrap(e, 20)); m_acc20 = wrap(e, 20);
    end
    if (last) begin
      x.d = m_acc32; x.o = m_ovf32; q32.push_back(x);
      x.d = m_acc20; x.o = m_ovf20; q20.push_back(x);
    end
    m_first = last;
  endtask

  task automatic model_reset();
    q32.delete(); q20.delete();
    m_first = 1; m_acc32 = 0; m_acc20 = 0; m_ovf32 = 0; m_ovf20 = 0;
  endtask

  // ---------------- acceptance and result monitors ----------------
  always @(negedge clk)
    if (!rst && in_valid && in_ready) model_beat(din_a, din_b, in_last);

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov32 && out_ready) begin
      if (q32.size() == 0) check("unexpected_result32", 1, 0);
      else begin
        e = q32.pop_front();
        check("dout32", longint'($signed(dout32)), e.d);
        check("ovf32", longint'(ovf32), longint'(e.o));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov20 && out_ready) begin
      if (q20.size() == 0) check("unexpected_result20", 1, 0);
      else begin
        e = q20.pop_front();
        check("dout20", longint'($signed(dout20)), e.d);
        check("ovf20", longint'(ovf20), longint'(e.o));
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [DOT*SA-1:0] fill(input byte v);
    return {DOT{v}};
  endfunction

  function automatic logic [DOT*SA-1:0] rnd();
    return (DOT*SA)'({$urandom(), $urandom()});
  endfunction

  task automatic send(input logic [DOT*SA-1:0] a, input logic [DOT*SB-1:0] b, input bit last);
    int n;
    n = 0;
    in_valid = 1'b1; in_last = last; din_a = a; din_b = b;
    @(negedge clk);
    while (!(in_ready && in_ready20) && n < 300) begin
      n++; stalls++;
      @(negedge clk);
    end
    if (n >= 300) check("send_timeout", n, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_result(input string nm);
    int n;
    n = 0;
    while (!ov32 && n < 60) begin @(posedge clk); #1; n++; end
    if (!ov32) check(nm, 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  bit done;

  initial begin
    int n;
    idle(3);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", ov32, 0);
    check("rst_dout", dout32, 0);
    check("rst_ovf", ovf32, 0);
    check("rst_out_valid20", ov20, 0);
    rst = 1'b0;
    idle(1);

    // single beat of ones: value and latency
    send(fill(1), fill(1), 1);
    n = 1;
    while (!ov32 && n < 20) begin @(posedge clk); #1; n++; end
    check("latency", n, 6);
    check("t1_dout", longint'($signed(dout32)), 6);
    idle(4);

    // extreme operands
    send(fill(-128), fill(-128), 1);
    wait_result("t2a_timeout");
    check("t2a_dout", longint'($signed(dout32)), 98304);
    for (int i = 0; i < 4; i++) send(fill(-128), fill(127), i == 3);
    wait_result("t2b_timeout");
    check("t2b_dout", longint'($signed(dout32)), -390144);
    idle(10);

    // back-to-back vectors 1,3,2
    stalls = 0;
    send(rnd(), rnd(), 1);
    for (int i = 0; i < 3; i++) send(rnd(), rnd(), i == 2);
    for (int i = 0; i < 2; i++) send(rnd(), rnd(), i == 1);
    check("b2b_stalls", stalls, 0);
    idle(12);

    // held result with beats streaming in behind it
    stalls = 0;
    out_ready = 1'b0;
    send(rnd(), rnd(), 1);
    fork
      begin
        for (int i = 0; i < 3; i++) send(rnd(), rnd(), i == 2);
        for (int i = 0; i < 4; i++) send(rnd(), rnd(), i == 3);
      end
      begin
        n = 0;
        while (!ov32 && n < 40) begin @(posedge clk); #1; n++; end
        idle(10);
        check("stall_in_ready", in_ready, 0);
        check("stall_held", ov32, 1);
        out_ready = 1'b1;
      end
    join
    check("stall_seen", longint'(stalls > 0), 1);
    idle(15);

    // overflow in the 20-bit accumulator, then a clean vector
    for (int i = 0; i < 6; i++) send(fill(-128), fill(-128), i == 5);
    wait_result("t5a_timeout");
    check("t5a_dout20", longint'($signed(dout20)), -458752);
    check("t5a_ovf20", ovf20, 1);
    check("t5a_dout32", longint'($signed(dout32)), 589824);
    send(fill(1), fill(1), 1);
    wait_result("t5b_timeout");
    check("t5b_dout20", longint'($signed(dout20)), 6);
    check("t5b_ovf20", ovf20, 0);
    idle(10);

    // randomized traffic with bubbles and back-pressure
    done = 0;
    fork
      begin
        for (int v = 0; v < 40; v++) begin
          int len;
          len = $urandom_range(1, 8);
          for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(rnd(), rnd(), b == len - 1);
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    idle(20);

    // reset mid-vector
    for (int i = 0; i < 2; i++) send(fill(5), fill(7), 0);
    rst = 1'b1;
    model_reset();
    idle(2);
    check("rst2_in_ready", in_ready, 1);
    check("rst2_out_valid", ov32, 0);
    check("rst2_dout", dout32, 0);
    check("rst2_ovf", ovf32, 0);
    rst = 1'b0;
    idle(1);
    send(fill(2), fill(3), 1);
    wait_result("t7_timeout");
    check("t7_dout", longint'($signed(dout32)), 36);
    idle(12);

    check("q32_drained", q32.size(), 0);
    check("q20_drained", q20.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
